sha256_link_ctrl: RTL and testbench

Controller between the UART byte link and the SHA-256 compression core. It collects 64 received bytes into a 512-bit block and starts the core. It then latches the 256-bit digest and streams it back as 32 bytes, MSB byte first, through the UART transmitter. Each 64-byte message is one pre-padded block hashed from the standard IV.

---
 rtl/sha256_link_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sha256_link_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_link_ctrl.sv
// sha256_link_ctrl: collects 64 UART bytes into a SHA-256 block, starts the core, streams the digest back.
// Optional partial-block idle timeout is compiled in with `define SHA_CTRL_TIMEOUT_EN.
module sha256_link_ctrl #(
    parameter int unsigned BLOCK_BYTES    = 64,
    parameter int unsigned DIGEST_BYTES   = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    output logic         core_start,
    output logic [511:0] core_block,
    input  logic         core_done,
    input  logic [255:0] core_digest,
    output logic         tx_start,
    output logic [7:0]   tx_data,
    input  logic         tx_done,
    output logic         busy,
    output logic         err_overrun,
    output logic         err_timeout
);

    typedef enum logic [2:0] {
        S_COLLECT,
        S_START,
        S_WAIT_CORE,
        S_SEND,
        S_SEND_WAIT
    } state_t;

    localparam logic [6:0] LAST_BYTE = 7'(BLOCK_BYTES - 1);
    localparam logic [4:0] LAST_TX   = 5'(DIGEST_BYTES - 1);

    state_t         r_state;
    logic [6:0]     r_byte_cnt;
    logic [4:0]     r_tx_idx;
    logic [511:0]   r_block;
    logic [255:0]   r_digest;
    logic           r_core_start;
    logic           r_tx_start;
    logic [7:0]     r_tx_data;
    logic           r_busy;
    logic           r_err_overrun;

    logic           w_expire;
    logic [6:0]     w_cnt;
    logic [8:0]     w_rx_msb;
    logic [7:0]     w_tx_msb;
    logic [7:0]     w_tx_byte;

    // Block and digest widths are fixed by the core; the idle counter is 20 bits.
    if (BLOCK_BYTES != 64 || DIGEST_BYTES != 32 ||
        TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 1048575) begin : g_bad_cfg
        $error("sha256_link_ctrl: unsupported parameter set");
    end

    // An expiring partial block makes the concurrent byte land in slot 0.
    assign w_cnt     = w_expire ? 7'd0 : r_byte_cnt;
    assign w_rx_msb  = 9'd511 - {w_cnt[5:0], 3'b000};
    assign w_tx_msb  = 8'd255 - {r_tx_idx, 3'b000};
    assign w_tx_byte = r_digest[w_tx_msb -: 8];

`ifdef SHA_CTRL_TIMEOUT_EN
    localparam logic [19:0] IDLE_LIMIT = 20'(TIMEOUT_CYCLES);

    logic [19:0] r_idle;
    logic        r_err_timeout;

    assign w_expire = (r_state == S_COLLECT) && (r_byte_cnt != 7'd0) &&
                      (r_idle == IDLE_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle        <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_expire) begin
                r_err_timeout <= 1'b1;
            end
            if (rx_valid || w_expire || r_state != S_COLLECT ||
                r_byte_cnt == 7'd0) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + 20'd1;
            end
        end
    end

    assign err_timeout = r_err_timeout;
`else
    assign w_expire    = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_COLLECT;
            r_byte_cnt    <= '0;
            r_tx_idx      <= '0;
            r_block       <= '0;
            r_digest      <= '0;
            r_core_start  <= 1'b0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= '0;
            r_busy        <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_core_start <= 1'b0;
            r_tx_start   <= 1'b0;
            if (rx_valid && r_state != S_COLLECT) begin
                r_err_overrun <= 1'b1;
            end
            unique case (r_state)
                S_COLLECT: begin
                    if (rx_valid) begin
                        r_block[w_rx_msb -: 8] <= rx_data;
                        r_byte_cnt             <= w_cnt + 7'd1;
                        if (w_cnt == LAST_BYTE) begin
                            r_state      <= S_START;
                            r_core_start <= 1'b1;
                            r_busy       <= 1'b1;
                        end
                    end else if (w_expire) begin
                        r_byte_cnt <= 7'd0;
                    end
                end
                S_START: begin
                    r_state <= S_WAIT_CORE;
                end
                S_WAIT_CORE: begin
                    if (core_done) begin
                        r_digest <= core_digest;
                        r_tx_idx <= '0;
                        r_state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_tx_data  <= w_tx_byte;
                    r_tx_start <= 1'b1;
                    r_state    <= S_SEND_WAIT;
                end
                S_SEND_WAIT: begin
                    if (tx_done) begin
                        r_tx_idx <= r_tx_idx + 5'd1;
                        if (r_tx_idx == LAST_TX) begin
                            r_state    <= S_COLLECT;
                            r_byte_cnt <= '0;
                            r_busy     <= 1'b0;
                        end else begin
                            r_state <= S_SEND;
                        end
                    end
                end
                default: begin
                    r_state <= S_COLLECT;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign core_start  = r_core_start;
    assign core_block  = r_block;
    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign busy        = r_busy;
    assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_sha256_link_ctrl.sv
// Bench for sha256_link_ctrl: model core and UART transmitter, digest bytes checked from a queue.
// With SHA_CTRL_TIMEOUT_EN the partial-block timeout is exercised at TIMEOUT_CYCLES = 100.
module tb_sha256_link_ctrl;

`ifdef SHA_CTRL_TIMEOUT_EN
    localparam int TO_CYC = 100;
`else
    localparam int TO_CYC = 1_000_000;
`endif

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 472'h0, 8'h18};
    localparam logic [511:0] EMPTY_BLK = {8'h80, 504'h0};
    localparam logic [255:0] ABC_DIG   =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIG =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rx_valid = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         core_start;
    logic [511:0] core_block;
    logic         core_done = 1'b0;
    logic [255:0] core_digest = '0;
    logic         tx_start;
    logic [7:0]   tx_data;
    logic         tx_done = 1'b0;
    logic         busy;
    logic         err_overrun;
    logic         err_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int core_lat = 1;
    int tx_lat   = 1;
    int tx_long  = 0;
    int done_cyc = 0;
    int txd_cyc  = 0;
    int n_starts = 0;
    int n_tx     = 0;
    int mon_idx  = 0;
    logic [7:0] exp_q[$];

    sha256_link_ctrl #(
        .BLOCK_BYTES   (64),
        .DIGEST_BYTES  (32),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .core_start (core_start),
        .core_block (core_block),
        .core_done  (core_done),
        .core_digest(core_digest),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .busy       (busy),
        .err_overrun(err_overrun),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] model_digest(input logic [511:0] blk);
        if (blk === ABC_BLK) return ABC_DIG;
        if (blk === EMPTY_BLK) return EMPTY_DIG;
        return blk[511:256] ^ blk[255:0] ^ {8{32'h5a5aa5a5}};
    endfunction

    // Model compression core: answers each core_start after core_lat cycles.
    initial begin
        logic [511:0] blk;
        logic [255:0] dig;
        forever begin
            @(negedge clk);
            if (!rst && core_start) begin
                n_starts++;
                blk = core_block;
                dig = model_digest(blk);
                repeat (core_lat) @(negedge clk);
                n_tests++;
                if (core_block !== blk) begin
                    n_fail++;
                    $display("FAIL core_block_hold: got %h, expected %h", core_block, blk);
                end
                core_digest = dig;
                core_done   = 1'b1;
                done_cyc    = cyc;
                @(negedge clk);
                core_done = 1'b0;
            end
        end
    end

    // Model transmitter: tx_done after tx_lat cycles, or 8680 for the next tx_long bytes.
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (!rst && tx_start) begin
                d = (tx_long > 0) ? 8680 : tx_lat;
                if (tx_long > 0) tx_long--;
                repeat (d) @(negedge clk);
                tx_done = 1'b1;
                txd_cyc = cyc;
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
    end

    // Scoreboard: each tx_start pops one expected byte and checks its spacing.
    initial begin
        logic [7:0] exp;
        int gap;
        forever begin
            @(negedge clk);
            if (!rst && tx_start) begin
                n_tx++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL tx_unexpected: got byte %02h, expected no byte", tx_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (tx_data !== exp) begin
                        n_fail++;
                        $display("FAIL tx_data[%0d]: got %02h, expected %02h", mon_idx, tx_data, exp);
                    end
                end
                gap = (mon_idx == 0) ? cyc - done_cyc : cyc - txd_cyc;
                n_tests++;
                if (gap != 2) begin
                    n_fail++;
                    $display("FAIL tx_spacing[%0d]: got %0d cycles, expected 2", mon_idx, gap);
                end
                mon_idx = (mon_idx + 1) % 32;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by 2 ms, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic push_digest(input logic [255:0] d);
        for (int k = 0; k < 32; k++) exp_q.push_back(d[255 - 8*k -: 8]);
    endtask

    task automatic send_bytes(input logic [511:0] blk, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            rx_valid = 1'b1;
            rx_data  = blk[511 - 8*k -: 8];
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok, output int t_end);
        ok = 1'b0;
        t_end = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && busy === 1'b0) begin
                ok = 1'b1;
                t_end = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL rst_core_start: got %b, expected 0", core_start); end
        n_tests++; if (core_block !== '0) begin n_fail++; $display("FAIL rst_core_block: got %h, expected 0", core_block); end
        n_tests++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_tx_start: got %b, expected 0", tx_start); end
        n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %02h, expected 00", tx_data); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        n_tests++; if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b, expected 0", err_overrun); end
        n_tests++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b, expected 0", err_timeout); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abc();
        bit ok;
        int t_end;
        push_digest(ABC_DIG);
        send_bytes(ABC_BLK, 0, 63);
        n_tests++; if (core_start !== 1'b1) begin n_fail++; $display("FAIL abc_start: got %b, expected 1", core_start); end
        n_tests++; if (core_block[511:480] !== 32'h61626380) begin n_fail++; $display("FAIL abc_head: got %h, expected 61626380", core_block[511:480]); end
        n_tests++; if (core_block[7:0] !== 8'h18) begin n_fail++; $display("FAIL abc_tail: got %02h, expected 18", core_block[7:0]); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abc_busy: got %b, expected 1", busy); end
        @(negedge clk);
        n_tests++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL abc_start_pulse: got %b, expected 0", core_start); end
        wait_idle(ok, t_end);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL abc_done: got timeout, expected 32 bytes"); end
        n_tests++; if (t_end - txd_cyc != 1) begin n_fail++; $display("FAIL abc_busy_fall: got %0d cycles, expected 1", t_end - txd_cyc); end
        n_tests++; if ({err_overrun, err_timeout} !== 2'b00) begin n_fail++; $display("FAIL abc_errs: got %b, expected 00", {err_overrun, err_timeout}); end
    endtask

    task automatic test_latency();
        bit ok;
        int t_end;
        int t0;
        t0 = n_tx;
        core_lat = 500;
        push_digest(ABC_DIG);
        send_bytes(ABC_BLK, 0, 63);
        wait_idle(ok, t_end);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL lat_core500: got timeout, expected 32 bytes"); end
        core_lat = 1;
        tx_long = 2;
        push_digest(EMPTY_DIG);
        send_bytes(EMPTY_BLK, 0, 63);
        wait_idle(ok, t_end);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL lat_tx8680: got timeout, expected 32 bytes"); end
        n_tests++; if (n_tx - t0 != 64) begin n_fail++; $display("FAIL lat_count: got %0d bytes, expected 64", n_tx - t0); end
    endtask

    task automatic test_overrun();
        bit ok;
        int t_end;
        core_lat = 300;
        push_digest(ABC_DIG);
        send_bytes(ABC_BLK, 0, 63);
        repeat (20) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        @(negedge clk);
        rx_valid = 1'b0;
        n_tests++; if (err_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b, expected 1", err_overrun); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ovr_busy: got %b, expected 1", busy); end
        wait_idle(ok, t_end);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL ovr_digest: got timeout, expected 32 bytes"); end
        core_lat = 1;
        push_digest(EMPTY_DIG);
        send_bytes(EMPTY_BLK, 0, 63);
        wait_idle(ok, t_end);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL ovr_second: got timeout, expected 32 bytes"); end
        n_tests++; if (err_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b, expected 1", err_overrun); end
    endtask

    task automatic test_midreset();
        bit ok;
        bit hit;
        int t_end;
        int t0;
        t0 = n_tx;
        hit = 1'b0;
        push_digest(ABC_DIG);
        send_bytes(ABC_BLK, 0, 63);
        for (int i = 0; i < 2000; i++) begin
            if (n_tx - t0 >= 10) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_tests++; if (!hit) begin n_fail++; $display("FAIL mrst_reach10: got %0d bytes, expected 10", n_tx - t0); end
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if ({core_start, tx_start, busy, err_overrun} !== 4'b0000) begin n_fail++; $display("FAIL mrst_flags: got %b, expected 0000", {core_start, tx_start, busy, err_overrun}); end
        n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL mrst_tx_data: got %02h, expected 00", tx_data); end
        n_tests++; if (core_block !== '0) begin n_fail++; $display("FAIL mrst_block: got %h, expected 0", core_block); end
        rst = 1'b0;
        exp_q.delete();
        mon_idx = 0;
        repeat (4) @(negedge clk);
        t0 = n_tx;
        push_digest(ABC_DIG);
        send_bytes(ABC_BLK, 0, 63);
        wait_idle(ok, t_end);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL mrst_fresh: got timeout, expected 32 bytes"); end
        n_tests++; if (n_tx - t0 != 32) begin n_fail++; $display("FAIL mrst_count: got %0d bytes, expected 32", n_tx - t0); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int t_end;
        int s0;
        int t0;
        s0 = n_starts;
        t0 = n_tx;
        push_digest(ABC_DIG);
        send_bytes(ABC_BLK, 0, 63);
        wait_idle(ok, t_end);
        push_digest(EMPTY_DIG);
        send_bytes(EMPTY_BLK, 0, 63);
        n_tests++; if (core_start !== 1'b1) begin n_fail++; $display("FAIL b2b_start: got %b, expected 1", core_start); end
        wait_idle(ok, t_end);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_done: got timeout, expected 64 bytes"); end
        n_tests++; if (n_starts - s0 != 2) begin n_fail++; $display("FAIL b2b_starts: got %0d, expected 2", n_starts - s0); end
        n_tests++; if (n_tx - t0 != 64) begin n_fail++; $display("FAIL b2b_count: got %0d bytes, expected 64", n_tx - t0); end
        n_tests++; if ({err_overrun, err_timeout} !== 2'b00) begin n_fail++; $display("FAIL b2b_errs: got %b, expected 00", {err_overrun, err_timeout}); end
    endtask

    task automatic test_idle();
        bit ok;
        int t_end;
`ifdef SHA_CTRL_TIMEOUT_EN
        send_bytes({64{8'haa}}, 0, 4);
        repeat (90) @(negedge clk);
        n_tests++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b, expected 0", err_timeout); end
        repeat (20) @(negedge clk);
        n_tests++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b, expected 1", err_timeout); end
        push_digest(ABC_DIG);
        send_bytes(ABC_BLK, 0, 63);
        n_tests++; if (core_start !== 1'b1) begin n_fail++; $display("FAIL to_start: got %b, expected 1", core_start); end
        n_tests++; if (core_block[511:504] !== 8'h61) begin n_fail++; $display("FAIL to_byte0: got %02h, expected 61", core_block[511:504]); end
`else
        send_bytes(ABC_BLK, 0, 4);
        repeat (200) @(negedge clk);
        n_tests++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL idle_timeout: got %b, expected 0", err_timeout); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b, expected 0", busy); end
        push_digest(ABC_DIG);
        send_bytes(ABC_BLK, 5, 63);
        n_tests++; if (core_start !== 1'b1) begin n_fail++; $display("FAIL idle_start: got %b, expected 1", core_start); end
        n_tests++; if (core_block[511:480] !== 32'h61626380) begin n_fail++; $display("FAIL idle_head: got %h, expected 61626380", core_block[511:480]); end
`endif
        wait_idle(ok, t_end);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL idle_digest: got timeout, expected 32 bytes"); end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_latency();
        test_overrun();
        test_midreset();
        test_back_to_back();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
